// File: rtl/matmul_pkg.sv
// Shared types and derived-constant helpers for the tiled matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_DONE      = 3'd4
    } sched_state_e;

    function automatic int unsigned row_tiles(input int unsigned i_outer, input int unsigned block);
        return i_outer / block;
    endfunction

    function automatic int unsigned col_tiles(input int unsigned w_outer, input int unsigned block);
        return w_outer / block;
    endfunction

    function automatic int unsigned k_steps(input int unsigned inner, input int unsigned chunk);
        return inner / chunk;
    endfunction

    function automatic int unsigned max_flag(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/matmul_tile_scheduler_tile_addr_gen.sv
// Nested k/b issue counters and the paired BRAM word-address computation for one tile.
module tile_addr_gen
    import matmul_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE      = 2,
    parameter int unsigned CHUNK_SIZE      = 4,
    parameter int unsigned INNER_DIMENSION = 4,
    parameter int unsigned ADDR_WIDTH      = 12
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  advance,
    input  logic [15:0]                           tile_row,
    input  logic [15:0]                           tile_col,
    output logic [clog2_min1(BLOCK_SIZE)-1:0]     lane,
    output logic                                  first,
    output logic                                  issue_last,
    output logic [ADDR_WIDTH-1:0]                 in_addr,
    output logic [ADDR_WIDTH-1:0]                 wb_addr
);

    localparam int unsigned KS     = k_steps(INNER_DIMENSION, CHUNK_SIZE);
    localparam int unsigned LANE_W = clog2_min1(BLOCK_SIZE);
    localparam int unsigned K_W    = clog2_min1(KS);
    localparam logic [LANE_W-1:0] B_MAX = LANE_W'(BLOCK_SIZE - 1);
    localparam logic [K_W-1:0]    K_MAX = K_W'(KS - 1);

    logic [LANE_W-1:0] b_r;
    logic [K_W-1:0]    k_r;

    // Counters point at the next read to issue; b is the inner loop, k the outer.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            b_r <= '0;
            k_r <= '0;
        end else if (advance) begin
            if (b_r == B_MAX) begin
                b_r <= '0;
                k_r <= (k_r == K_MAX) ? '0 : k_r + 1'b1;
            end else begin
                b_r <= b_r + 1'b1;
                k_r <= k_r;
            end
        end else begin
            b_r <= b_r;
            k_r <= k_r;
        end
    end

    // Row-major word addresses at 32 bits, truncated to the port width.
    always_comb begin
        lane       = b_r;
        first      = (b_r == '0) && (k_r == '0);
        issue_last = (b_r == B_MAX) && (k_r == K_MAX);
        in_addr    = ADDR_WIDTH'((32'(tile_row) * 32'(BLOCK_SIZE) + 32'(b_r)) * 32'(KS) + 32'(k_r));
        wb_addr    = ADDR_WIDTH'((32'(tile_col) * 32'(BLOCK_SIZE) + 32'(b_r)) * 32'(KS) + 32'(k_r));
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Tile-by-tile sequencer: issues paired BRAM reads, aligned feed strobes and accumulator
// clears to the systolic core, and waits for the core between tiles.
module matmul_tile_scheduler
    import matmul_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE        = 2,
    parameter int unsigned CHUNK_SIZE        = 4,
    parameter int unsigned INNER_DIMENSION   = 4,
    parameter int unsigned I_OUTER_DIMENSION = 6,
    parameter int unsigned W_OUTER_DIMENSION = 6,
    parameter int unsigned ADDR_WIDTH        = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              start,
    output logic                              ready,
    output logic                              done,
    output logic                              in_enb,
    output logic                              wb_enb,
    output logic [ADDR_WIDTH-1:0]             in_addrb,
    output logic [ADDR_WIDTH-1:0]             wb_addrb,
    output logic                              acc_clr,
    output logic                              feed_valid,
    output logic [clog2_min1(BLOCK_SIZE)-1:0] feed_lane,
    output logic                              feed_last,
    input  logic                              core_done,
    output logic [15:0]                       tile_row,
    output logic [15:0]                       tile_col
);

    localparam int unsigned ROWS   = row_tiles(I_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned COLS   = col_tiles(W_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int unsigned TILES  = max_flag(ROWS, COLS);
    localparam int unsigned LANE_W = clog2_min1(BLOCK_SIZE);
    localparam logic [15:0] COL_MAX   = 16'(COLS - 1);
    localparam logic [31:0] LAST_TILE = 32'(TILES - 1);

    sched_state_e      state_r;
    sched_state_e      state_s;
    logic [31:0]       tile_idx_r;
    logic [31:0]       tile_idx_s;
    logic [15:0]       tile_row_s;
    logic [15:0]       tile_col_s;
    logic              tile_last_s;
    logic              advance_tile_s;
    logic              emit_s;
    logic              issue_last_r;
    logic [LANE_W-1:0] issue_lane_r;

    logic [LANE_W-1:0]     gen_lane_s;
    logic                  gen_first_s;
    logic                  gen_last_s;
    logic [ADDR_WIDTH-1:0] gen_in_addr_s;
    logic [ADDR_WIDTH-1:0] gen_wb_addr_s;

    logic                  in_enb_s;
    logic                  acc_clr_s;
    logic                  last_s;
    logic                  done_s;
    logic [LANE_W-1:0]     lane_s;
    logic [ADDR_WIDTH-1:0] in_addr_s;
    logic [ADDR_WIDTH-1:0] wb_addr_s;

    assign tile_last_s = (tile_idx_r == LAST_TILE);

    // The generator sees next-cycle tile indices so the first read of a new tile is correct.
    tile_addr_gen #(
        .BLOCK_SIZE      (BLOCK_SIZE),
        .CHUNK_SIZE      (CHUNK_SIZE),
        .INNER_DIMENSION (INNER_DIMENSION),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .advance    (emit_s),
        .tile_row   (tile_row_s),
        .tile_col   (tile_col_s),
        .lane       (gen_lane_s),
        .first      (gen_first_s),
        .issue_last (gen_last_s),
        .in_addr    (gen_in_addr_s),
        .wb_addr    (gen_wb_addr_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ISSUE ends once the read on the bus is the tile's last.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_ISSUE;
                else       state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (issue_last_r) state_s = ST_DRAIN;
                else              state_s = ST_ISSUE;
            end
            ST_DRAIN: state_s = ST_WAIT_CORE;
            ST_WAIT_CORE: begin
                if (core_done) begin
                    if (tile_last_s) state_s = ST_DONE;
                    else             state_s = ST_ISSUE;
                end else begin
                    state_s = ST_WAIT_CORE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs and tile counters.
    always_comb begin
        emit_s         = (state_s == ST_ISSUE);
        advance_tile_s = (state_r == ST_WAIT_CORE) && core_done && !tile_last_s;
        if (state_s == ST_IDLE) begin
            tile_idx_s = '0;
            tile_row_s = '0;
            tile_col_s = '0;
        end else if (advance_tile_s) begin
            tile_idx_s = tile_idx_r + 32'd1;
            if (tile_col == COL_MAX) begin
                tile_col_s = '0;
                tile_row_s = tile_row + 16'd1;
            end else begin
                tile_col_s = tile_col + 16'd1;
                tile_row_s = tile_row;
            end
        end else begin
            tile_idx_s = tile_idx_r;
            tile_row_s = tile_row;
            tile_col_s = tile_col;
        end
        in_enb_s  = emit_s;
        acc_clr_s = emit_s && gen_first_s;
        last_s    = emit_s && gen_last_s;
        lane_s    = emit_s ? gen_lane_s : '0;
        in_addr_s = emit_s ? gen_in_addr_s : '0;
        wb_addr_s = emit_s ? gen_wb_addr_s : '0;
        done_s    = (state_s == ST_DONE);
    end

    // Output registers; the feed stage trails the issue stage by the BRAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            done         <= 1'b0;
            in_enb       <= 1'b0;
            wb_enb       <= 1'b0;
            acc_clr      <= 1'b0;
            in_addrb     <= '0;
            wb_addrb     <= '0;
            issue_lane_r <= '0;
            issue_last_r <= 1'b0;
            feed_valid   <= 1'b0;
            feed_lane    <= '0;
            feed_last    <= 1'b0;
            tile_idx_r   <= '0;
            tile_row     <= '0;
            tile_col     <= '0;
        end else begin
            done         <= done_s;
            in_enb       <= in_enb_s;
            wb_enb       <= in_enb_s;
            acc_clr      <= acc_clr_s;
            in_addrb     <= in_addr_s;
            wb_addrb     <= wb_addr_s;
            issue_lane_r <= lane_s;
            issue_last_r <= last_s;
            feed_valid   <= in_enb;
            feed_lane    <= issue_lane_r;
            feed_last    <= issue_last_r;
            tile_idx_r   <= tile_idx_s;
            tile_row     <= tile_row_s;
            tile_col     <= tile_col_s;
        end
    end

    // Ready is decoded straight from the state register.
    always_comb begin
        ready = (state_r == ST_IDLE);
    end

endmodule

// File: doc/matmul_tile_scheduler.md
# matmul_tile_scheduler

Sequencer for the tiled matrix-multiply core. It walks the output matrix tile by tile and issues paired read addresses to the input BRAM and weight BRAM port B. It sends read-data-aligned feed strobes and accumulator clears to the systolic core, then waits for the core's completion before moving to the next tile. It sits between the top-level start/ready/done control port and the BRAM/core datapath, and replaces the free-running main counter.

## Interface
- `BLOCK_SIZE`, 2: systolic array dimension N; rows per tile.
- `CHUNK_SIZE`, 4: elements per BRAM word.
- `INNER_DIMENSION`, 4: shared dimension K; must be a multiple of `CHUNK_SIZE`.
- `I_OUTER_DIMENSION`, 6: input rows; must be a multiple of `BLOCK_SIZE`.
- `W_OUTER_DIMENSION`, 6: weight rows; must be a multiple of `BLOCK_SIZE`.
- `ADDR_WIDTH`, 12: BRAM port-B address width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `clr`  in  1: synchronous clear; same effect as reset.
- `start`  in  1: begin one full matrix pass; sampled only while `ready`.
- `ready`  out  1: high in IDLE.
- `done`  out  1: one-cycle pulse at end of pass.
- `in_enb`, `wb_enb`  out  1: BRAM port-B read enables; always equal to each other.
- `in_addrb`, `wb_addrb`  out  `ADDR_WIDTH`: BRAM read addresses.
- `acc_clr`  out  1: one-cycle pulse; clears core accumulators.
- `feed_valid`  out  1: BRAM read data valid this cycle.
- `feed_lane`  out  clog2(`BLOCK_SIZE`) (min 1): array row/column lane of current data.
- `feed_last`  out  1: final feed of current tile.
- `core_done`  in  1: core finished current tile (accumulator_done).
- `tile_row`, `tile_col`  out  16: current tile indices.

## Operation
- Derived constants:
  - `ROW_TILES` = `I_OUTER_DIMENSION` / `BLOCK_SIZE`.
  - `COL_TILES` = `W_OUTER_DIMENSION` / `BLOCK_SIZE`.
  - `K_STEPS` = `INNER_DIMENSION` / `CHUNK_SIZE`.
  - `T` = `K_STEPS` * `BLOCK_SIZE` (issue cycles per tile).
  - `MAX_FLAG` = `ROW_TILES` * `COL_TILES`.
- Memory layout: row r, chunk k lives at word address r*`K_STEPS`+k, in both BRAMs.
- Tile order is row-major: `tile_col` is the inner loop, `tile_row` the outer.
- Within a tile, `k` is the outer loop (0..`K_STEPS`-1) and `b` the inner loop (0..`BLOCK_SIZE`-1). Each cycle issues:
  - `in_addrb` = (`tile_row`*`BLOCK_SIZE`+b)*`K_STEPS`+k
  - `wb_addrb` = (`tile_col`*`BLOCK_SIZE`+b)*`K_STEPS`+k
- Address arithmetic is computed at 32 bits and truncated to `ADDR_WIDTH`. Out-of-range configurations are not checked.
- States:
  - IDLE: `ready`=1. `start` → ISSUE with tile (0,0).
  - ISSUE: `T` cycles with `in_enb`=`wb_enb`=1. `acc_clr`=1 on the first cycle only. After the `T`th cycle → DRAIN.
  - DRAIN: one cycle; last `feed_valid` (with `feed_last`=1) → WAIT_CORE.
  - WAIT_CORE: hold until `core_done`.
    - If the tile is last → DONE.
    - Otherwise advance tile (col+1, wrapping to 0 with row+1) → ISSUE.
  - DONE: `done`=1 for one cycle → IDLE.
- `feed_valid`, `feed_lane` and `feed_last` are the issue-cycle values delayed one cycle, matching BRAM READ_LATENCY 1.
- Boundary rules:
  - `start` outside IDLE is ignored.
  - `start` in the DONE cycle is ignored; the next pass needs `start` while `ready`.
  - `core_done` outside WAIT_CORE is ignored and is not remembered.
  - `core_done` arriving on the first WAIT_CORE cycle is accepted.
  - `rst_n`=0 or `clr`=1 mid-pass aborts immediately: IDLE next cycle, all counters zeroed, no `done` pulse, and the feed pipeline is flushed (`feed_valid`=0).
  - `tile_row` and `tile_col` hold their values through WAIT_CORE and DONE. They are zeroed on entry to IDLE.

## Timing
- Reset values:
  - `ready`=1.
  - All other outputs 0: `done`, `in_enb`, `wb_enb`, `acc_clr`, `feed_valid`, `feed_last`, addresses, `feed_lane`, `tile_row`, `tile_col`.
- All outputs are registered, except `ready`, which is decoded from the state register.
- Per-tile cycle timeline, with `start` (or the accepted `core_done`) seen at cycle 0:
  - Cycle 1: `acc_clr`=1, first read issued.
  - Cycles 1..`T`: `in_enb`/`wb_enb` high.
  - Cycles 2..`T`+1: `feed_valid` high; `feed_last` at cycle `T`+1.
  - Cycle `T`+2 onward: WAIT_CORE.
- Tile-to-tile gap: the next ISSUE begins the cycle after `core_done`.
- `done` asserts the cycle after the final `core_done`; `ready` rises the cycle after that.

## Structure
- A shared package `matmul_pkg` holds:
  - the state enumeration;
  - the derived-constant functions (`ROW_TILES`, `COL_TILES`, `K_STEPS`, `MAX_FLAG`);
  - the address-width helper (clog2).
- One sub-module, `tile_addr_gen`: the nested k/b counters plus the address multiply-add. It takes `tile_row`/`tile_col` and exposes `issue_last`.
- The FSM, tile counters and feed delay pipeline live in `matmul_tile_scheduler`.

## Test plan
- Defaults (`T`=2): reset → `ready`=1, all other outputs 0. Pulse `start` → `acc_clr` at cycle 1; `in_addrb`=0,1 and `wb_addrb`=0,1 on cycles 1–2; `feed_valid` on cycles 2–3 with `feed_lane`=0,1 and `feed_last` at cycle 3.
- Defaults, tile (1,2): `in_addrb`=2,3 and `wb_addrb`=4,5. Full pass requires 9 `core_done` pulses, then `done` pulses once and `ready` returns.
- `INNER_DIMENSION`=8 (`K_STEPS`=2), tile (0,0): `in_addrb` sequence 0,2,1,3; `feed_last` only on the 4th feed.
- `core_done` held high throughout: each tile's WAIT_CORE lasts exactly one cycle. `start` pulsed mid-pass → no effect. `core_done` pulsed during ISSUE → ignored; the tile still waits in WAIT_CORE.
- `clr` asserted during ISSUE of tile 4 → next cycle IDLE, `ready`=1, `feed_valid`=0, no `done`. A subsequent `start` restarts at tile (0,0) with addresses 0,1.
